// File: rtl/clock_time_keeper_hex_if.sv
// Time-keeper bus: overwrite request from the controller, packed time and tick pulses back.
// The hold signal exists only when CLOCK_HOLD_EN is defined.
interface clock_time_keeper_hex_if;
  logic [16:0] time_in;
  logic        time_ow;
  logic [16:0] time_out;
  logic        sec_tick;
  logic        day_tick;
`ifdef CLOCK_HOLD_EN
  logic        hold;

  modport master (output time_in, time_ow, hold, input time_out, sec_tick, day_tick);
  modport slave  (input time_in, time_ow, hold, output time_out, sec_tick, day_tick);
`else
  modport master (output time_in, time_ow, input time_out, sec_tick, day_tick);
  modport slave  (input time_in, time_ow, output time_out, sec_tick, day_tick);
`endif
endinterface

// File: rtl/clock_time_keeper_hex.sv
// Time-of-day keeper: prescales clk to a 1 s tick and counts hh:mm:ss packed as hhhhh_mmmmmm_ssssss.
// Optional freeze input enabled by defining CLOCK_HOLD_EN.
module clock_time_keeper_hex #(
  parameter int CLK_FREQ = 100_000_000
) (
  input logic                    clk,
  input logic                    rst_n,
  clock_time_keeper_hex_if.slave bus
);

  localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_FREQ - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [4:0]    hour_q, hour_d;
  logic [5:0]    min_q, min_d;
  logic [5:0]    sec_q, sec_d;
  logic          sec_tick_q, sec_tick_d;
  logic          day_tick_q, day_tick_d;
  logic          run;
  logic          tick;

  // Out-of-range overwrite fields collapse to zero, each independently.
  function automatic logic [4:0] clamp_hour(input logic [4:0] h);
    return (h > 5'd23) ? 5'd0 : h;
  endfunction

  function automatic logic [5:0] clamp_min_sec(input logic [5:0] v);
    return (v > 6'd59) ? 6'd0 : v;
  endfunction

`ifdef CLOCK_HOLD_EN
  assign run = ~bus.hold;
`else
  assign run = 1'b1;
`endif

  assign tick = run && (presc_q == PRESC_MAX);

  always_comb begin
    presc_d    = presc_q;
    hour_d     = hour_q;
    min_d      = min_q;
    sec_d      = sec_q;
    sec_tick_d = 1'b0;
    day_tick_d = 1'b0;

    if (bus.time_ow) begin
      hour_d  = clamp_hour(bus.time_in[16:12]);
      min_d   = clamp_min_sec(bus.time_in[11:6]);
      sec_d   = clamp_min_sec(bus.time_in[5:0]);
      presc_d = '0;
    end else if (tick) begin
      presc_d    = '0;
      sec_tick_d = 1'b1;
      // Full carry chain resolves in this one cycle.
      if (sec_q == 6'd59) begin
        sec_d = 6'd0;
        if (min_q == 6'd59) begin
          min_d = 6'd0;
          if (hour_q == 5'd23) begin
            hour_d     = 5'd0;
            day_tick_d = 1'b1;
          end else begin
            hour_d = hour_q + 5'd1;
          end
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end else if (run) begin
      presc_d = presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= '0;
      hour_q     <= '0;
      min_q      <= '0;
      sec_q      <= '0;
      sec_tick_q <= 1'b0;
      day_tick_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      hour_q     <= hour_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      sec_tick_q <= sec_tick_d;
      day_tick_q <= day_tick_d;
    end
  end

  assign bus.time_out = {hour_q, min_q, sec_q};
  assign bus.sec_tick = sec_tick_q;
  assign bus.day_tick = day_tick_q;

endmodule

// File: tb/tb_clock_time_keeper_hex.sv
// Directed bench for clock_time_keeper_hex at CLK_FREQ=4 with a scoreboard of expected outputs.
module tb_clock_time_keeper_hex;

  logic clk = 1'b0;
  logic rst_n;

  clock_time_keeper_hex_if ifc();

  clock_time_keeper_hex #(.CLK_FREQ(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [18:0] v;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [16:0] hms(input int h, input int m, input int s);
    return {5'(h), 6'(m), 6'(s)};
  endfunction

  task automatic push_exp(input string tag, input logic [16:0] t, input logic st, input logic dt);
    sb.push_back('{tag, {t, st, dt}});
  endtask

  task automatic compare_front();
    exp_t        e;
    logic [18:0] obs;
    obs = {ifc.time_out, ifc.sec_tick, ifc.day_tick};
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty got %h exp none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.v)
      else begin
        errors++;
        $error("FAIL %s got time=%h sec=%b day=%b exp time=%h sec=%b day=%b",
               e.tag, obs[18:2], obs[1], obs[0], e.v[18:2], e.v[1], e.v[0]);
      end
    end
  endtask

  task automatic check_now(input string tag, input logic [16:0] t, input logic st, input logic dt);
    push_exp(tag, t, st, dt);
    compare_front();
  endtask

  task automatic cyc(input string tag, input logic [16:0] t, input logic st, input logic dt);
    push_exp(tag, t, st, dt);
    @(posedge clk);
    #1;
    compare_front();
  endtask

  task automatic same(input int n, input string tag, input logic [16:0] t);
    repeat (n) cyc(tag, t, 1'b0, 1'b0);
  endtask

  task automatic load(input string tag, input logic [16:0] raw, input logic [16:0] expv);
    ifc.time_ow = 1'b1;
    ifc.time_in = raw;
    cyc(tag, expv, 1'b0, 1'b0);
    ifc.time_ow = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    ifc.time_in = '0;
    ifc.time_ow = 1'b0;
`ifdef CLOCK_HOLD_EN
    ifc.hold = 1'b0;
`endif
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_now("rst_async", 17'd0, 1'b0, 1'b0);
    cyc("rst_held", 17'd0, 1'b0, 1'b0);
    cyc("rst_held", 17'd0, 1'b0, 1'b0);

    // Reset release and first two seconds.
    rst_n = 1'b1;
    same(3, "rst_first", 17'd0);
    cyc("first_sec", hms(0, 0, 1), 1'b1, 1'b0);
    same(3, "sec_period", hms(0, 0, 1));
    cyc("next_sec", hms(0, 0, 2), 1'b1, 1'b0);

    // Day rollover.
    load("ow_2359", hms(23, 59, 59), hms(23, 59, 59));
    same(3, "pre_roll", hms(23, 59, 59));
    cyc("day_roll", 17'd0, 1'b1, 1'b1);
    cyc("post_roll", 17'd0, 1'b0, 1'b0);

    // Minute and hour carries.
    load("ow_123459", hms(12, 34, 59), hms(12, 34, 59));
    same(3, "pre_min", hms(12, 34, 59));
    cyc("min_carry", hms(12, 35, 0), 1'b1, 1'b0);
    load("ow_125959", hms(12, 59, 59), hms(12, 59, 59));
    same(3, "pre_hour", hms(12, 59, 59));
    cyc("hour_carry", hms(13, 0, 0), 1'b1, 1'b0);

    // Range clamping.
    load("clamp_25_30_60", {5'd25, 6'd30, 6'd60}, hms(0, 30, 0));
    load("clamp_all_ones", {5'd31, 6'd63, 6'd63}, 17'd0);
    load("clamp_min60", {5'd23, 6'd60, 6'd5}, hms(23, 0, 5));
    load("clamp_hr24", {5'd24, 6'd59, 6'd59}, hms(0, 59, 59));

    // Overwrite coincident with tick.
    load("ow_0900", hms(9, 0, 0), hms(9, 0, 0));
    same(3, "pre_beat", hms(9, 0, 0));
    load("ow_beats_tick", hms(10, 0, 0), hms(10, 0, 0));
    same(3, "after_beat", hms(10, 0, 0));
    cyc("beat_next", hms(10, 0, 1), 1'b1, 1'b0);

    // Level-sensitive overwrite held over several edges.
    ifc.time_ow = 1'b1;
    ifc.time_in = hms(1, 2, 3);
    cyc("ow_level", hms(1, 2, 3), 1'b0, 1'b0);
    cyc("ow_level", hms(1, 2, 3), 1'b0, 1'b0);
    ifc.time_in = hms(1, 2, 4);
    cyc("ow_level_new", hms(1, 2, 4), 1'b0, 1'b0);
    ifc.time_ow = 1'b0;
    same(3, "ow_level_rel", hms(1, 2, 4));
    cyc("ow_level_tick", hms(1, 2, 5), 1'b1, 1'b0);

    // Asynchronous reset mid-second.
    same(2, "pre_rst_mid", hms(1, 2, 5));
    #2 rst_n = 1'b0;
    #1 check_now("rst_mid_async", 17'd0, 1'b0, 1'b0);
    cyc("rst_mid_held", 17'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    same(3, "rst_mid_restart", 17'd0);
    cyc("rst_mid_first", hms(0, 0, 1), 1'b1, 1'b0);

`ifdef CLOCK_HOLD_EN
    same(2, "pre_hold", hms(0, 0, 1));
    ifc.hold = 1'b1;
    same(10, "hold_frozen", hms(0, 0, 1));
    ifc.hold = 1'b0;
    cyc("hold_rel1", hms(0, 0, 1), 1'b0, 1'b0);
    cyc("hold_tick", hms(0, 0, 2), 1'b1, 1'b0);
    ifc.hold = 1'b1;
    load("hold_ow", hms(3, 0, 0), hms(3, 0, 0));
    same(5, "hold_ow_frozen", hms(3, 0, 0));
    ifc.hold = 1'b0;
    same(3, "hold_ow_rel", hms(3, 0, 0));
    cyc("hold_ow_tick", hms(3, 0, 1), 1'b1, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
